// File: rtl/mem_byte_access_unit.sv
// MEM-stage access unit: serialises word/halfword loads and word stores onto an
// 8-bit req/ack memory port and returns sign- or zero-extended load data.
module mem_byte_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        load_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic              is_half;
    logic              is_signed;

    logic [1:0]        next_idx;
    logic              last;
    logic [31:0]       assembled;
    logic [31:0]       load_result;
    logic              req_half;
    logic [ADDR_W-1:0] req_base;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        next_idx  = idx + 2'd1;
        last      = is_half ? (idx == 2'd1) : (idx == 2'd3);
        assembled = asm_q;
        assembled[{idx, 3'b000} +: 8] = mem_rdata;
        if (is_half)
            load_result = is_signed ? {{16{assembled[15]}}, assembled[15:0]}
                                    : {16'h0000, assembled[15:0]};
        else
            load_result = assembled;
        // Stores are always words; misaligned addresses are silently aligned down.
        req_half = !MemWrite && (load_mode == 2'b01 || load_mode == 2'b10);
        req_base = req_half ? {addr[ADDR_W-1:1], 1'b0} : {addr[ADDR_W-1:2], 2'b00};
        stall    = (state == XFER) || (state == IDLE && (MemRead || MemWrite));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            base      <= '0;
            wdata_q   <= 32'h0;
            asm_q     <= 32'h0;
            is_half   <= 1'b0;
            is_signed <= 1'b0;
            rdata     <= 32'h0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (MemWrite || MemRead) begin
                        state     <= XFER;
                        idx       <= 2'd0;
                        base      <= req_base;
                        wdata_q   <= wdata;
                        asm_q     <= 32'h0;
                        is_half   <= req_half;
                        is_signed <= (load_mode == 2'b01);
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= req_base;
                        mem_wdata <= MemWrite ? wdata[7:0] : 8'h00;
                    end
                end
                XFER: begin
                    // Port outputs only move on ack, so they hold through wait states.
                    if (mem_ack) begin
                        if (!mem_we)
                            asm_q <= assembled;
                        if (last) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            idx       <= 2'd0;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_wdata <= 8'h00;
                            if (!mem_we)
                                rdata <= load_result;
                        end else begin
                            idx      <= next_idx;
                            mem_addr <= base + ADDR_W'(next_idx);
                            if (mem_we)
                                mem_wdata <= wdata_q[{next_idx, 3'b000} +: 8];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_access_unit.sv
// Directed bench for mem_byte_access_unit: byte memory responder with configurable
// wait states, transfer log, and linear stimulus with hand-computed expectations.
module tb_mem_byte_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite;
    logic [1:0]  load_mode;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [0:4095];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    bit          stray_ack = 1'b0;
    int          stable_err = 0;
    logic [31:0] held_addr;
    logic        held_we;
    logic [7:0]  held_wdata;

    logic [31:0] addr_log[$];
    logic        we_log[$];
    logic [7:0]  wdata_log[$];

    mem_byte_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .load_mode(load_mode), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Responder: decides ack on the falling edge, holding off wait_cfg cycles per byte.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (!mem_req) begin
            mem_ack  = stray_ack;
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) begin
                held_addr  = mem_addr;
                held_we    = mem_we;
                held_wdata = mem_wdata;
            end else if (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wdata) begin
                stable_err++;
            end
            if (wait_cnt >= wait_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:0]];
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && mem_req && mem_ack) begin
            addr_log.push_back(mem_addr);
            we_log.push_back(mem_we);
            wdata_log.push_back(mem_wdata);
            if (mem_we)
                mem[mem_addr[11:0]] = mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in cycle 0, drops it afterwards, and returns in the
    // IDLE cycle right after DONE (or after the cycle budget runs out).
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] mode,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int done_cyc, output int stall_cnt);
        addr_log.delete();
        we_log.delete();
        wdata_log.delete();
        MemRead   = rd;
        MemWrite  = wr;
        load_mode = mode;
        addr      = a;
        wdata     = wd;
        done_cyc  = -1;
        stall_cnt = 0;
        #1;
        for (int c = 0; c < 100; c++) begin
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = c;
                tick();
                break;
            end
            tick();
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    endtask

    int dc, sc;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h78; mem[12'h101] = 8'h56;
        mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
        mem[12'h200] = 8'h34; mem[12'h201] = 8'hF2;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        MemRead = 1'b0; MemWrite = 1'b0; load_mode = 2'b00; addr = 32'h0; wdata = 32'h0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_mem_req", {31'h0, mem_req}, 32'h0);
        check("reset_mem_we", {31'h0, mem_we}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Word load at misaligned 0x102 is aligned to 0x100.
        do_access(1'b1, 1'b0, 2'b00, 32'h102, 32'h0, dc, sc);
        check("lw_done_cycle", 32'(dc), 32'd5);
        check("lw_stall_cycles", 32'(sc), 32'd5);
        check("lw_rdata", rdata, 32'h12345678);
        check("lw_xfer_count", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            check($sformatf("lw_addr%0d", i), addr_log[i], 32'h100 + 32'(i));
            check($sformatf("lw_we%0d", i), {31'h0, we_log[i]}, 32'h0);
        end

        do_access(1'b1, 1'b0, 2'b01, 32'h201, 32'h0, dc, sc);
        check("lh_done_cycle", 32'(dc), 32'd3);
        check("lh_stall_cycles", 32'(sc), 32'd3);
        check("lh_rdata", rdata, 32'hFFFFF234);
        check("lh_xfer_count", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() > 0) check("lh_addr0", addr_log[0], 32'h200);

        do_access(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, dc, sc);
        check("lhu_done_cycle", 32'(dc), 32'd3);
        check("lhu_rdata", rdata, 32'h0000F234);

        // Store leaves rdata at the lhu result.
        do_access(1'b0, 1'b1, 2'b00, 32'h300, 32'hDEADBEEF, dc, sc);
        check("sw_done_cycle", 32'(dc), 32'd5);
        check("sw_rdata_kept", rdata, 32'h0000F234);
        check("sw_xfer_count", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            check($sformatf("sw_addr%0d", i), addr_log[i], 32'h300 + 32'(i));
            check($sformatf("sw_we%0d", i), {31'h0, we_log[i]}, 32'h1);
        end
        if (wdata_log.size() == 4) begin
            check("sw_wdata0", {24'h0, wdata_log[0]}, 32'hEF);
            check("sw_wdata1", {24'h0, wdata_log[1]}, 32'hBE);
            check("sw_wdata2", {24'h0, wdata_log[2]}, 32'hAD);
            check("sw_wdata3", {24'h0, wdata_log[3]}, 32'hDE);
        end

        // Two wait states per byte: 4 x 3 cycles of XFER.
        wait_cfg = 2;
        stable_err = 0;
        do_access(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, dc, sc);
        check("wait_done_cycle", 32'(dc), 32'd13);
        check("wait_rdata", rdata, 32'h12345678);
        check("wait_port_stable", 32'(stable_err), 32'd0);
        wait_cfg = 0;

        // Read and write together: only the write happens.
        do_access(1'b1, 1'b1, 2'b01, 32'h304, 32'hCAFEF00D, dc, sc);
        check("both_done_cycle", 32'(dc), 32'd5);
        check("both_xfer_count", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < we_log.size(); i++)
            check($sformatf("both_we%0d", i), {31'h0, we_log[i]}, 32'h1);
        check("both_rdata_kept", rdata, 32'h12345678);
        // Back-to-back load in the IDLE cycle after DONE.
        do_access(1'b1, 1'b0, 2'b00, 32'h304, 32'h0, dc, sc);
        check("b2b_done_cycle", 32'(dc), 32'd5);
        check("b2b_rdata", rdata, 32'hCAFEF00D);

        // Reset during the third byte of a word load.
        MemRead = 1'b1; load_mode = 2'b00; addr = 32'h100;
        tick();
        MemRead = 1'b0;
        tick();
        tick();
        check("mid_in_xfer", {31'h0, mem_req}, 32'h1);
        check("mid_third_addr", mem_addr, 32'h102);
        reset_n = 1'b0;
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        stray_ack = 1'b1;
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        check("stray_ack_mem_req", {31'h0, mem_req}, 32'h0);
        check("stray_ack_done", {31'h0, done}, 32'h0);
        check("stray_ack_stall", {31'h0, stall}, 32'h0);
        check("stray_ack_rdata", rdata, 32'h0);
        stray_ack = 1'b0;
        tick();

        do_access(1'b1, 1'b0, 2'b00, 32'h102, 32'h0, dc, sc);
        check("post_rst_done_cycle", 32'(dc), 32'd5);
        check("post_rst_rdata", rdata, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_byte_access_unit.md
# mem_byte_access_unit

MEM-stage access unit of the pipelined MIPS core: the consumer of the decoder's memory controls `MemRead`, `MemWrite` and `load_mode`. It turns one word or halfword load/store from the EX/MEM pipeline register into a sequence of byte transfers on an 8-bit req/ack memory port. It stalls the pipeline while busy and returns the assembled, sign- or zero-extended load data to the writeback path.

## Interface
- `ADDR_W`, default 32: width of the byte address on both the pipeline side and the memory side.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request from EX/MEM register.
- `MemWrite`  in  1  store request (always a word store, `sw`).
- `load_mode`  in  2  load size: 00 word (`lw`), 01 halfword signed (`lh`), 10 halfword unsigned (`lhu`), 11 treated as word.
- `addr`  in  ADDR_W  effective byte address from the ALU.
- `wdata`  in  32  store data.
- `rdata`  out  32  assembled load result.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
- `done`  out  1  one-cycle pulse when an access completes.
- `mem_req`  out  1  byte transfer request.
- `mem_we`  out  1  1 = byte write, 0 = byte read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  byte address of the current transfer.
- `mem_wdata`  out  8  write byte.
- `mem_rdata`  in  8  read byte; sampled when `mem_ack` is high.
- `mem_ack`  in  1  memory completes the current byte this cycle.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If `MemWrite` is high, or `MemRead` is high, latch `addr`, `wdata`, `load_mode` and the direction, then go to XFER.
  - `MemWrite` has priority when both are high; the read is dropped.
  - Byte count: 4 for word (`load_mode` 00/11, and all stores), 2 for halfword.
- Alignment is forced, never trapped:
  - word base address = `addr` with bits [1:0] cleared;
  - halfword base address = `addr` with bit [0] cleared.
- XFER:
  - `mem_req` = 1; `mem_addr` = base + byte index (index 0 first).
  - Writes: `mem_we` = 1, `mem_wdata` = `wdata` byte [index] (little-endian).
  - Reads: `mem_we` = 0; on `mem_ack`, `mem_rdata` goes into assembly byte [index].
  - On `mem_ack` the index increments. If the index was the last one, go to DONE; otherwise stay in XFER with the next address on the following cycle.
  - `mem_addr`, `mem_we` and `mem_wdata` hold stable while `mem_ack` is low. Unbounded wait states are allowed.
- DONE:
  - `done` = 1 and `stall` = 0; go to IDLE unconditionally.
  - Inputs are ignored in DONE; the pipeline advances at the end of this cycle.
- `rdata` on load completion:
  - word: the 4 assembled bytes;
  - `lh`: sign-extend from bit 15;
  - `lhu`: zero-extend.
  - `rdata` updates in the cycle DONE is entered and holds until the next load completes. Stores leave it unchanged.
- `stall` = (state == XFER) OR (state == IDLE AND (`MemRead` OR `MemWrite`)). This is combinational, so the requesting cycle is already stalled.

## Timing
- Reset values: state IDLE, `rdata` 0, `stall` 0 (when no request is present), `done` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, byte index 0.
- Assertion of `reset_n` low mid-transfer takes effect immediately, without waiting for a clock edge:
  - `mem_req` drops, the FSM returns to IDLE, and the partial assembly is discarded.
  - A late `mem_ack` after reset is ignored.
- Latency with zero-wait memory (`mem_ack` high whenever `mem_req` is high), with request in cycle 0:
  - word: XFER in cycles 1-4, DONE in cycle 5, 5 stall cycles;
  - halfword: XFER in cycles 1-2, DONE in cycle 3, 3 stall cycles.
- Each wait-state cycle (`mem_req` high, `mem_ack` low) adds exactly one cycle.
- Back-to-back accesses: a new request can be accepted in the IDLE cycle immediately after DONE. There is no dead cycle beyond DONE.
- `mem_ack` is ignored outside XFER.

## Test plan
- Word load, zero-wait memory holding bytes 0x78, 0x56, 0x34, 0x12 at 0x100..0x103, `addr` = 0x102:
  - required: `mem_addr` sequence 0x100, 0x101, 0x102, 0x103;
  - `done` in cycle 5; `rdata` = 0x12345678; `stall` high in cycles 0-4.
- `lh` at 0x200 with bytes 0x34, 0xF2:
  - required: `rdata` = 0xFFFFF234.
  - Same bytes with `lhu`: required `rdata` = 0x0000F234. Each takes 2 transfers with `done` in cycle 3.
- `sw` of 0xDEADBEEF to 0x300:
  - required: `mem_we` = 1 and `mem_wdata` sequence 0xEF, 0xBE, 0xAD, 0xDE at 0x300..0x303;
  - `rdata` keeps its previous value.
- Word load with `mem_ack` delayed 2 cycles on every byte:
  - required: `done` in cycle 13;
  - `mem_addr` and `mem_we` stable throughout each wait.
- `MemRead` and `MemWrite` both high:
  - required: a write sequence is performed and no read transfer occurs.
  - Then, a load presented in the cycle right after DONE: required to be accepted with no idle gap.
- `reset_n` pulsed low during the third byte of a word load:
  - required: `mem_req` = 0, `stall` = 0 and `done` = 0 immediately;
  - `rdata` = 0; after release, a fresh load completes correctly.
